// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control types: register-address type, controller state
// encoding and the source/destination match helper.
package pipe_ctrl_pkg;

  typedef logic [4:0] reg_addr_t;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DSTALL = 2'd1,
    ST_MWAIT  = 2'd2,
    ST_FLUSH  = 2'd3
  } pipe_state_e;

  localparam int unsigned CNT_W = 32;

  // x0 is hardwired to zero, so a read of it never depends on an older write.
  function automatic logic src_match(input logic used, input reg_addr_t src,
                                     input reg_addr_t rd, input logic wren);
    return used && (src != '0) && wren && (src == rd);
  endfunction

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Read-after-write hazard compare between the ID-stage sources and the
// destinations still in flight in ID/EX, EX/MEM and MEM/WB.
module hazard_detect
  import pipe_ctrl_pkg::*;
#(
  parameter bit RF_BYPASS = 1'b0
) (
  input  reg_addr_t rs1_addr_i,
  input  logic      rs1_used_i,
  input  reg_addr_t rs2_addr_i,
  input  logic      rs2_used_i,
  input  reg_addr_t idex_rd_addr_i,
  input  logic      idex_rd_wren_i,
  input  reg_addr_t exmem_rd_addr_i,
  input  logic      exmem_rd_wren_i,
  input  reg_addr_t memwb_rd_addr_i,
  input  logic      memwb_rd_wren_i,
  output logic      hazard_o
);

  logic hz_idex, hz_exmem, hz_memwb;

  assign hz_idex  = src_match(rs1_used_i, rs1_addr_i, idex_rd_addr_i, idex_rd_wren_i)
                  | src_match(rs2_used_i, rs2_addr_i, idex_rd_addr_i, idex_rd_wren_i);
  assign hz_exmem = src_match(rs1_used_i, rs1_addr_i, exmem_rd_addr_i, exmem_rd_wren_i)
                  | src_match(rs2_used_i, rs2_addr_i, exmem_rd_addr_i, exmem_rd_wren_i);
  // A write-through register file already returns the MEM/WB value in ID.
  assign hz_memwb = !RF_BYPASS &&
                    (src_match(rs1_used_i, rs1_addr_i, memwb_rd_addr_i, memwb_rd_wren_i)
                   | src_match(rs2_used_i, rs2_addr_i, memwb_rd_addr_i, memwb_rd_wren_i));

  assign hazard_o = hz_idex | hz_exmem | hz_memwb;

endmodule

// File: rtl/pipe_ctrl.sv
// Five-stage pipeline controller: per-cycle stall/flush decisions, a
// registered view of the last cycle's class, perf counters and memory timeout.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MAX_WAIT  = 16,  // must be >= 1
  parameter bit          RF_BYPASS = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  reg_addr_t        id_rs1_addr_i,
  input  reg_addr_t        id_rs2_addr_i,
  input  logic             id_rs1_used_i,
  input  logic             id_rs2_used_i,
  input  reg_addr_t        idex_rd_addr_i,
  input  reg_addr_t        exmem_rd_addr_i,
  input  reg_addr_t        memwb_rd_addr_i,
  input  logic             idex_rd_wren_i,
  input  logic             exmem_rd_wren_i,
  input  logic             memwb_rd_wren_i,
  input  logic             exmem_br_sel_i,
  input  logic             exmem_jump_i,
  input  logic             exmem_mem_req_i,
  input  logic             mem_ready_i,
  output logic             pc_en_o,
  output logic             ifid_en_o,
  output logic             idex_en_o,
  output logic             exmem_en_o,
  output logic             memwb_en_o,
  output logic             ifid_flush_o,
  output logic             idex_flush_o,
  output logic             exmem_flush_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic             timeout_o
);

  localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  pipe_state_e       state_q, state_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              timeout_q, timeout_d;
  logic              hazard, mwait, redirect;

  hazard_detect #(.RF_BYPASS(RF_BYPASS)) u_hazard (
    .rs1_addr_i      (id_rs1_addr_i),
    .rs1_used_i      (id_rs1_used_i),
    .rs2_addr_i      (id_rs2_addr_i),
    .rs2_used_i      (id_rs2_used_i),
    .idex_rd_addr_i  (idex_rd_addr_i),
    .idex_rd_wren_i  (idex_rd_wren_i),
    .exmem_rd_addr_i (exmem_rd_addr_i),
    .exmem_rd_wren_i (exmem_rd_wren_i),
    .memwb_rd_addr_i (memwb_rd_addr_i),
    .memwb_rd_wren_i (memwb_rd_wren_i),
    .hazard_o        (hazard)
  );

  // A redirect held in EX/MEM is masked while memory is busy and acts in the
  // cycle mem_ready_i rises.
  assign mwait    = exmem_mem_req_i & ~mem_ready_i;
  assign redirect = (exmem_br_sel_i | exmem_jump_i) & ~mwait;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_RUN;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      wait_cnt_q  <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  always_comb begin
    state_d = ST_RUN;
    if (mwait)         state_d = ST_MWAIT;
    else if (redirect) state_d = ST_FLUSH;
    else if (hazard)   state_d = ST_DSTALL;
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    wait_cnt_d  = '0;
    if (state_d == ST_DSTALL || state_d == ST_MWAIT) stall_cnt_d = stall_cnt_q + 32'd1;
    if (state_d == ST_FLUSH) flush_cnt_d = flush_cnt_q + 32'd1;
    if (state_d == ST_MWAIT) begin
      wait_cnt_d = (wait_cnt_q == WAIT_MAX) ? wait_cnt_q : wait_cnt_q + WAIT_W'(1);
    end
    timeout_d = timeout_q | (wait_cnt_d == WAIT_MAX);
  end

  always_comb begin
    pc_en_o       = 1'b1;
    ifid_en_o     = 1'b1;
    idex_en_o     = 1'b1;
    exmem_en_o    = 1'b1;
    memwb_en_o    = 1'b1;
    ifid_flush_o  = 1'b0;
    idex_flush_o  = 1'b0;
    exmem_flush_o = 1'b0;
    if (rst_i) begin
      ifid_flush_o  = 1'b1;
      idex_flush_o  = 1'b1;
      exmem_flush_o = 1'b1;
    end else begin
      case (state_d)
        ST_MWAIT: begin
          pc_en_o    = 1'b0;
          ifid_en_o  = 1'b0;
          idex_en_o  = 1'b0;
          exmem_en_o = 1'b0;
          memwb_en_o = 1'b0;
        end
        ST_FLUSH: begin
          ifid_flush_o  = 1'b1;
          idex_flush_o  = 1'b1;
          exmem_flush_o = 1'b1;
        end
        ST_DSTALL: begin
          pc_en_o      = 1'b0;
          ifid_en_o    = 1'b0;
          idex_flush_o = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign state_o     = state_q;
  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
  assign timeout_o   = timeout_q;

endmodule
